// File: rtl/uart_dac_main.sv
// Generic first-word-fall-through FIFO used for the per-DAC word queues.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: pushes while full are discarded; pop_rdy only takes effect while pop_vld.
module fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_vld = (wr_ptr != rd_ptr);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy && pop_vld) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// UART command bridge: 8N1 bytes fill per-DAC 24-bit word FIFOs and trigger serial DAC frames.
// Latency: echo and command action start the cycle after the stop-bit sample; frames begin 2 cycles later.
// Backpressure: none on the UART; words to a full FIFO and bytes arriving during an echo are not kept/echoed.
module uart_dac_main #(
    parameter int DACN         = 2,
    parameter int CLKS_PER_BIT = 26,
    parameter int FIFO_DEPTH   = 4,
    parameter int TESTBENCH    = 0
) (
    input  logic            clk_50,
    input  logic            reset_button,
    input  logic            uart_rx,
    output logic            uart_tx,
    output logic            on_led,
    output logic            fifo_empty_led_and,
    output logic            fifo_empty_led_or,
    input  logic [DACN-1:0] dac_busy_n,
    output logic [DACN-1:0] dac_sdo,
    output logic [DACN-1:0] dac_sclk,
    output logic [DACN-1:0] dac_sync_n,
    output logic [DACN-1:0] dac_reset_n,
    output logic [DACN-1:0] dac_clr_n,
    output logic [DACN-1:0] dac_ldac_n
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0]    DACN_W   = 5'(DACN);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_D0, P_D1, P_D2} p_state_t;
    typedef enum logic [1:0] {SH_IDLE, SH_WAIT, SH_FRAME} sh_state_t;

    logic [19:0] por_cnt;
    logic        por_done;

    always_ff @(posedge clk_50 or negedge reset_button) begin
        if (!reset_button) begin
            por_cnt  <= '0;
            por_done <= 1'b0;
        end else if (!por_done) begin
            por_cnt <= por_cnt + 20'd1;
            if (TESTBENCH != 0 || &por_cnt) por_done <= 1'b1;
        end
    end

    assign on_led      = por_done;
    assign dac_reset_n = {DACN{por_done}};
    assign dac_clr_n   = {DACN{por_done}};

    // ---------------- UART receive ----------------
    rx_state_t     rx_st, rx_nxt;
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [6:0]    rx_shift;
    logic [7:0]    uart_rx_data;
    logic          rx_tick;
    logic          rx_valid;

    always_comb begin
        rx_nxt   = rx_st;
        rx_tick  = 1'b0;
        rx_valid = 1'b0;
        case (rx_st)
            RX_IDLE:  if (por_done && rx_prev && !rx_s) rx_nxt = RX_START;
            RX_START: if (rx_cnt == HALF_END) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_cnt == BIT_END) begin
                rx_tick = 1'b1;
                if (rx_bit == 3'd7) rx_nxt = RX_STOP;
            end
            RX_STOP: if (rx_cnt == BIT_END) begin
                rx_valid = rx_s;
                rx_nxt   = RX_IDLE;
            end
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_button) begin
        if (!reset_button) begin
            rx_st        <= RX_IDLE;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            uart_rx_data <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            rx_st   <= rx_nxt;
            rx_cnt  <= (rx_st == RX_IDLE || rx_nxt != rx_st || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_st != RX_DATA) begin
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_s, rx_shift[6:1]};
                if (rx_bit == 3'd7) uart_rx_data <= {rx_s, rx_shift};
            end
        end
    end

    // ---------------- UART echo ----------------
    logic [9:0]    tx_shift;
    logic [3:0]    tx_left;
    logic [CW-1:0] tx_cnt;

    always_ff @(posedge clk_50 or negedge reset_button) begin
        if (!reset_button) begin
            tx_shift <= '1;
            tx_left  <= '0;
            tx_cnt   <= '0;
        end else if (tx_left == 4'd0) begin
            if (rx_valid) begin
                tx_shift <= {1'b1, uart_rx_data, 1'b0};
                tx_left  <= 4'd10;
                tx_cnt   <= '0;
            end
        end else if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_left  <= tx_left - 4'd1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign uart_tx = (tx_left == 4'd0) ? 1'b1 : tx_shift[0];

    // ---------------- command parser ----------------
    p_state_t    p_st, p_nxt;
    logic [3:0]  chan;
    logic [15:0] word_hi;
    logic        word_push, xmit, ldac_go;
    logic [2:0]  ldac_cnt;

    always_comb begin
        p_nxt     = p_st;
        word_push = 1'b0;
        xmit      = 1'b0;
        ldac_go   = 1'b0;
        if (rx_valid) begin
            case (p_st)
                P_IDLE: case (uart_rx_data[7:4])
                    4'h2:    if ({1'b0, uart_rx_data[3:0]} < DACN_W) p_nxt = P_D0;
                    4'h3:    xmit = 1'b1;
                    4'h4:    ldac_go = 1'b1;
                    default: ;
                endcase
                P_D0:    p_nxt = P_D1;
                P_D1:    p_nxt = P_D2;
                P_D2: begin
                    p_nxt     = P_IDLE;
                    word_push = 1'b1;
                end
                default: p_nxt = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge reset_button) begin
        if (!reset_button) begin
            p_st     <= P_IDLE;
            chan     <= '0;
            word_hi  <= '0;
            ldac_cnt <= '0;
        end else begin
            p_st <= p_nxt;
            if (rx_valid && p_st == P_IDLE) chan <= uart_rx_data[3:0];
            if (rx_valid && (p_st == P_D0 || p_st == P_D1)) word_hi <= {word_hi[7:0], uart_rx_data};
            if (ldac_go)                  ldac_cnt <= 3'd4;
            else if (ldac_cnt != 3'd0)    ldac_cnt <= ldac_cnt - 3'd1;
        end
    end

    assign dac_ldac_n = {DACN{ldac_cnt == 3'd0}};

    // ---------------- per-DAC queue and shifter ----------------
    logic [DACN-1:0] fifo_empty;

    for (genvar k = 0; k < DACN; k++) begin : g_dac
        sh_state_t   sh_st, sh_nxt;
        logic        pop_vld;
        logic [23:0] pop_dat;
        logic [5:0]  sh_cnt;
        logic [23:0] sh_reg;

        fifo #(.W(24), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk_50),
            .rst_n    (reset_button),
            .push_vld (word_push && (chan == 4'(k))),
            .push_dat ({word_hi, uart_rx_data}),
            .pop_vld  (pop_vld),
            .pop_rdy  (xmit && sh_st == SH_IDLE),
            .pop_dat  (pop_dat)
        );

        always_comb begin
            sh_nxt = sh_st;
            case (sh_st)
                SH_IDLE:  if (xmit && pop_vld) sh_nxt = SH_WAIT;
                SH_WAIT:  if (dac_busy_n[k]) sh_nxt = SH_FRAME;
                SH_FRAME: if (sh_cnt == 6'd48) sh_nxt = SH_IDLE;
                default:  sh_nxt = SH_IDLE;
            endcase
        end

        // Cycle 0 presents the MSB; odd cycles hold sclk low, and data advances as sclk rises.
        always_ff @(posedge clk_50 or negedge reset_button) begin
            if (!reset_button) begin
                sh_st  <= SH_IDLE;
                sh_cnt <= '0;
                sh_reg <= '0;
            end else begin
                sh_st  <= sh_nxt;
                sh_cnt <= (sh_st == SH_FRAME) ? sh_cnt + 6'd1 : 6'd0;
                if (sh_st == SH_IDLE && sh_nxt == SH_WAIT) sh_reg <= pop_dat;
                else if (sh_st == SH_FRAME && sh_cnt[0])   sh_reg <= {sh_reg[22:0], 1'b0};
            end
        end

        assign fifo_empty[k] = !pop_vld;
        assign dac_sync_n[k] = (sh_st != SH_FRAME);
        assign dac_sclk[k]   = !(sh_st == SH_FRAME && sh_cnt[0]);
        assign dac_sdo[k]    = (sh_st == SH_FRAME) && sh_reg[23];
    end

    assign fifo_empty_led_and = &fifo_empty;
    assign fifo_empty_led_or  = |fifo_empty;
endmodule

// File: tb/tb_uart_dac_main.sv
// Directed bench for uart_dac_main: UART commands in, echo and DAC frames observed and compared.
module tb_uart_dac_main;
    localparam int DACN = 2;
    localparam int CPB  = 26;

    logic            clk_50 = 1'b0;
    logic            reset_button;
    logic            uart_rx;
    logic            uart_tx, on_led, fifo_empty_led_and, fifo_empty_led_or;
    logic [DACN-1:0] dac_busy_n, dac_sdo, dac_sclk, dac_sync_n, dac_reset_n, dac_clr_n, dac_ldac_n;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc++;

    uart_dac_main #(.DACN(DACN), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .TESTBENCH(1)) dut (
        .clk_50             (clk_50),
        .reset_button       (reset_button),
        .uart_rx            (uart_rx),
        .uart_tx            (uart_tx),
        .on_led             (on_led),
        .fifo_empty_led_and (fifo_empty_led_and),
        .fifo_empty_led_or  (fifo_empty_led_or),
        .dac_busy_n         (dac_busy_n),
        .dac_sdo            (dac_sdo),
        .dac_sclk           (dac_sclk),
        .dac_sync_n         (dac_sync_n),
        .dac_reset_n        (dac_reset_n),
        .dac_clr_n          (dac_clr_n),
        .dac_ldac_n         (dac_ldac_n)
    );

    // Receive-valid pulses, frame statistics and ldac pulses, sampled on the falling edge.
    int          rxv_cnt = 0;
    logic [23:0] cap [DACN];
    int          nframe [DACN];
    int          fstart [DACN];
    int          run_low [DACN];
    int          run_fall [DACN];
    logic [DACN-1:0] sclk_q = '1;
    logic [DACN-1:0] sync_q = '1;
    int          ldac_run = 0;
    int          ldac_last = 0;
    int          ldac_pulses = 0;

    always @(negedge clk_50) begin
        if (dut.rx_valid === 1'b1) rxv_cnt++;
        for (int k = 0; k < DACN; k++) begin
            if (dac_sync_n[k] === 1'b0) begin
                if (sync_q[k]) begin
                    nframe[k]++;
                    fstart[k]   = cyc;
                    run_low[k]  = 0;
                    run_fall[k] = 0;
                end
                run_low[k]++;
                if (sclk_q[k] && !dac_sclk[k]) begin
                    run_fall[k]++;
                    cap[k] = {cap[k][22:0], dac_sdo[k]};
                end
            end
        end
        sclk_q = dac_sclk;
        sync_q = dac_sync_n;
        if (dac_ldac_n == 2'b00) begin
            ldac_run++;
        end else if (ldac_run != 0) begin
            ldac_last = ldac_run;
            ldac_pulses++;
            ldac_run = 0;
        end
    end

    // Decodes the echoed bytes on uart_tx.
    logic [7:0] echo_q[$];
    initial begin
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk_50);
            if (reset_button === 1'b1 && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk_50);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_50);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk_50);
                if (uart_tx === 1'b1) echo_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    logic [7:0] mid_data;
    int         mid_rxv;
    logic [7:0] exp_echo[$];

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_ok;
        tick(6);
        mid_data = dut.uart_rx_data;
        mid_rxv  = rxv_cnt;
        tick(CPB - 6);
        uart_rx = 1'b1;
        tick(30);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        exp_echo.push_back(b);
    endtask

    task automatic send_word(input logic [3:0] ch, input logic [23:0] w);
        send_good({4'h2, ch});
        send_good(w[23:16]);
        send_good(w[15:8]);
        send_good(w[7:0]);
    endtask

    task automatic wait_frame(input int k, input int base);
        int n;
        n = 0;
        while (n < 400 && !(nframe[k] > base && dac_sync_n[k] === 1'b1)) begin
            @(negedge clk_50);
            n++;
        end
    endtask

    int b0, b1, r0, rel;

    initial begin
        for (int k = 0; k < DACN; k++) begin
            nframe[k] = 0; fstart[k] = 0; run_low[k] = 0; run_fall[k] = 0; cap[k] = '0;
        end
        uart_rx      = 1'b1;
        dac_busy_n   = '1;
        reset_button = 1'b0;
        tick(5);
        @(negedge clk_50);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_on_led", on_led, 0);
        chk("rst_sdo", dac_sdo, 2'b00);
        chk("rst_sclk", dac_sclk, 2'b11);
        chk("rst_sync_n", dac_sync_n, 2'b11);
        chk("rst_reset_n", dac_reset_n, 2'b00);
        chk("rst_clr_n", dac_clr_n, 2'b00);
        chk("rst_ldac_n", dac_ldac_n, 2'b11);
        chk("rst_leds", {fifo_empty_led_and, fifo_empty_led_or}, 2'b11);

        tick(1);
        reset_button = 1'b1;
        tick(3);
        @(negedge clk_50);
        chk("run_on_led", on_led, 1);
        chk("run_reset_n", dac_reset_n, 2'b11);
        chk("run_clr_n", dac_clr_n, 2'b11);
        chk("run_sync_n", dac_sync_n, 2'b11);
        chk("run_leds", {fifo_empty_led_and, fifo_empty_led_or}, 2'b11);
        chk("run_uart_tx", uart_tx, 1);

        // First byte: register content before stop bit, valid after it.
        tick(1);
        r0 = rxv_cnt;
        send_good(8'h21);
        chk("rx_data_before_stop", mid_data, 8'h21);
        chk("rx_valid_not_before_stop", mid_rxv, r0);
        chk("rx_valid_after_stop", rxv_cnt, r0 + 1);
        send_good(8'h21);
        send_good(8'h21);
        send_good(8'h21);
        @(negedge clk_50);
        chk("leds_after_word1", {fifo_empty_led_and, fifo_empty_led_or}, 2'b01);
        tick(1);
        send_word(4'h0, 24'h202020);
        @(negedge clk_50);
        chk("leds_after_word2", {fifo_empty_led_and, fifo_empty_led_or}, 2'b00);

        // Transmit: both DACs frame in the same cycle.
        tick(1);
        b0 = nframe[0]; b1 = nframe[1];
        send_good(8'h30);
        wait_frame(0, b0);
        wait_frame(1, b1);
        chk("x1_dac1_word", cap[1], 24'h212121);
        chk("x1_dac0_word", cap[0], 24'h202020);
        chk("x1_dac1_falls", run_fall[1], 24);
        chk("x1_dac0_falls", run_fall[0], 24);
        chk("x1_dac1_sync_len", run_low[1], 49);
        chk("x1_dac0_sync_len", run_low[0], 49);
        chk("x1_same_start", fstart[1] - fstart[0], 0);
        chk("x1_one_frame", (nframe[0] - b0) + (nframe[1] - b1), 2);
        chk("x1_leds", {fifo_empty_led_and, fifo_empty_led_or}, 2'b11);

        // Load strobe.
        tick(1);
        r0 = ldac_pulses;
        send_good(8'h40);
        tick(20);
        @(negedge clk_50);
        chk("ldac_pulses", ldac_pulses - r0, 1);
        chk("ldac_len", ldac_last, 4);
        chk("ldac_idle", dac_ldac_n, 2'b11);

        // Command-valued bytes inside a word are plain data.
        tick(1);
        r0 = ldac_pulses; b0 = nframe[0]; b1 = nframe[1];
        send_word(4'h1, 24'hA55A3C);
        send_word(4'h0, 24'h30415F);
        @(negedge clk_50);
        chk("data_bytes_no_ldac", ldac_pulses - r0, 0);
        chk("data_bytes_no_frame", (nframe[0] - b0) + (nframe[1] - b1), 0);

        // Busy DAC0 waits, DAC1 proceeds.
        tick(1);
        dac_busy_n = 2'b10;
        send_good(8'h30);
        wait_frame(1, b1);
        chk("busy_dac1_word", cap[1], 24'hA55A3C);
        chk("busy_dac1_falls", run_fall[1], 24);
        tick(20);
        @(negedge clk_50);
        chk("busy_dac0_held", nframe[0] - b0, 0);
        chk("busy_dac0_sync", dac_sync_n[0], 1);
        tick(1);
        dac_busy_n = 2'b11;
        rel = cyc;
        wait_frame(0, b0);
        chk("busy_dac0_word", cap[0], 24'h30415F);
        chk("busy_dac0_falls", run_fall[0], 24);
        chk("busy_dac0_start_after_release", (fstart[0] > rel) && (fstart[0] <= rel + 3), 1);

        // Bad stop bit: no valid, no echo, no action.
        tick(1);
        r0 = rxv_cnt; b0 = ldac_pulses;
        send_byte(8'h40, 1'b0);
        tick(10);
        chk("badstop_no_valid", rxv_cnt, r0);
        chk("badstop_no_ldac", ldac_pulses - b0, 0);

        // Fifth word into a four-deep FIFO is dropped.
        for (int w = 1; w <= 5; w++) send_word(4'h1, {3{8'(w)}});
        @(negedge clk_50);
        chk("full_leds", {fifo_empty_led_and, fifo_empty_led_or}, 2'b01);
        for (int w = 1; w <= 4; w++) begin
            tick(1);
            b1 = nframe[1];
            send_good(8'h30);
            wait_frame(1, b1);
            chk($sformatf("full_pop%0d_word", w), cap[1], {3{8'(w)}});
        end
        chk("full_drained_leds", {fifo_empty_led_and, fifo_empty_led_or}, 2'b11);
        tick(1);
        b1 = nframe[1];
        send_good(8'h30);
        tick(80);
        chk("full_fifth_dropped", nframe[1] - b1, 0);

        // Echo stream and valid count over the whole run.
        tick(300);
        chk("rx_valid_total", rxv_cnt, exp_echo.size());
        chk("echo_count", echo_q.size(), exp_echo.size());
        for (int i = 0; i < exp_echo.size() && i < echo_q.size(); i++)
            chk($sformatf("echo_byte%0d", i), echo_q[i], exp_echo[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
